// File: rtl/serial_adder.sv
// Bit-serial adder: sum/cout = a + b + cin, one bit per clock, LSB first.
// One full-adder cell and a carry flop; start/done handshake with a busy flag.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b, acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bit_s, c_nxt;
  logic [WIDTH-1:0] acc_nxt;

  // Full-adder cell on the current LSBs; the new sum bit enters the accumulator MSB
  always_comb begin
    bit_s   = sh_a[0] ^ sh_b[0] ^ carry;
    c_nxt   = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    acc_nxt = {bit_s, acc[WIDTH-1:1]};
  end

  // Sequencer: accept in IDLE/DONE, shift WIDTH times in RUN, publish result on the last edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE drops back to IDLE unless a new request arrives on this edge
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= c_nxt;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            // Last bit: the carry register still holds the carry into the MSB
            sum   <= acc_nxt;
            cout  <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ c_nxt;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder: computes a + b + cin one bit per clock, LSB first, using one full-adder cell and a carry flip-flop.
- Counterpart of the team's ripple-borrow subtractor. It trades area for latency and supplies the addition half of the arithmetic datapath.
- Used by sequencing logic that needs a start/done handshake instead of a combinational result.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress (RUN).
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result of the last completed addition, modulo 2^WIDTH.
- cout  output  1  carry-out of the last completed addition.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry and counter cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE to RUN:
  - Taken on the edge where start=1; this is the accepting edge E0.
  - Load shA=a, shB=b, carry=cin, cnt=0, busy=1.
- RUN, each edge:
  - s = shA[0] ^ shB[0] ^ carry.
  - carry <= maj(shA[0], shB[0], carry).
  - The accumulator shifts right with s entering at the MSB.
  - shA and shB shift right; cnt increments.
- RUN to DONE:
  - Taken on the edge where cnt reaches WIDTH-1, i.e. the WIDTH-th RUN edge, E(WIDTH).
  - On that edge: sum <= final accumulator (including the last bit), cout <= final carry, busy=0, done=1.
- DONE lasts exactly one cycle.
  - On the next edge, done=0.
  - If start=1 on that edge, the request is accepted as from IDLE: back-to-back operation, state RUN.
  - Otherwise the state returns to IDLE.
- Latency: done is high in the cycle after edge E(WIDTH), i.e. WIDTH clocks after acceptance. Throughput is one result per WIDTH+1 cycles.
- start during RUN is ignored. No queuing; the in-flight operation is unaffected.
- sum/cout are stable throughout RUN. They hold the previous result until the DONE update, and hold after DONE until the next completion or reset.
- a/b/cin may change freely after the accepting edge.
- Arithmetic is unsigned, modulo 2^WIDTH, with cout equal to bit WIDTH of the true sum.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced; sum/cout read 0.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Extra output port ovf (1 bit).
  - Carry into the MSB position is captured during the last RUN cycle.
  - ovf <= carry_into_MSB ^ carry_out, updated together with sum/cout on E(WIDTH).
  - ovf reflects two's-complement signed overflow; reset value 0; holds like sum.
- Without the macro: no ovf port and no extra flops; all other behaviour is identical.

Test Plan:
- Basic add: rst pulse, then a=0x25, b=0x3C, cin=0, start for 1 cycle -> busy=1 for 8 cycles; done pulse 8 clocks after acceptance; sum=0x61, cout=0.
- Wrap and carry: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Ignore while busy: start a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 at RUN cycle 3 -> single done; sum=0x30. No second operation starts.
- Back-to-back: hold start=1 continuously with a=0x01, b=0x02, then a=0x80, b=0x80 in the DONE cycle -> done pulses 9 cycles apart; results are 0x03/cout 0, then 0x00/cout 1.
- Reset mid-operation: start a=0xF0, b=0x0F, assert rst at RUN cycle 4 (asynchronous, between edges) -> busy, done, sum and cout all 0 immediately. After release, a fresh 0x12+0x34 yields sum=0x46.
- SERIAL_ADDER_OVF_EN build: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. Then a=0xFF, b=0x01 -> ovf=0.
